// File: rtl/car_sensor_conditioner.sv
// Synchronizes, debounces and holds a farm-road loop detector, drives car_present and counts departures.
// Optional stuck-high detection is compiled in with `define CAR_SENSOR_STUCK_DETECT_EN.
module car_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       loop_raw,
  output logic       car_present,
  output logic [7:0] car_count,
  output logic       fault
);

  // state    | meaning
  // IDLE     | no car, waiting for a high sample
  // ARRIVING | counting consecutive highs toward presence
  // PRESENT  | car declared present
  // LEAVING  | counting consecutive lows, presence still held
  // FAULT    | detector stuck high, output forced to NO (stuck-detect builds only)
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARRIVING = 3'd1,
    S_PRESENT  = 3'd2,
`ifdef CAR_SENSOR_STUCK_DETECT_EN
    S_LEAVING  = 3'd3,
    S_FAULT    = 3'd4
`else
    S_LEAVING  = 3'd3
`endif
  } state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_car_present;
  logic [7:0] r_car_count;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_count_inc;
  logic       w_s;
  logic       w_present_nxt;

  assign w_s = r_sync2;

`ifdef CAR_SENSOR_STUCK_DETECT_EN
  localparam logic [15:0] STUCK_LAST = 16'(STUCK_CYCLES - 1);
  logic [15:0] r_stuck_cnt;
  logic [15:0] w_stuck_nxt;
  logic        r_fault;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_count_inc = 1'b0;
`ifdef CAR_SENSOR_STUCK_DETECT_EN
    w_stuck_nxt = r_stuck_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_s) begin
          w_state_nxt = S_ARRIVING;
          w_cnt_nxt   = 8'd1;
        end
      end
      S_ARRIVING: begin
        if (!w_s) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = S_PRESENT;
          w_cnt_nxt   = 8'd0;
`ifdef CAR_SENSOR_STUCK_DETECT_EN
          w_stuck_nxt = 16'd0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_PRESENT: begin
        if (!w_s) begin
          w_state_nxt = S_LEAVING;
          w_cnt_nxt   = 8'd1;
        end else begin
`ifdef CAR_SENSOR_STUCK_DETECT_EN
          if (r_stuck_cnt == STUCK_LAST) begin
            w_state_nxt = S_FAULT;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_stuck_nxt = r_stuck_cnt + 16'd1;
          end
`endif
        end
      end
      // A return to PRESENT keeps the stuck count so dropouts cannot mask a stuck detector.
      S_LEAVING: begin
        if (w_s) begin
          w_state_nxt = S_PRESENT;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
          w_count_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
`ifdef CAR_SENSOR_STUCK_DETECT_EN
      S_FAULT: begin
        if (w_s) begin
          w_cnt_nxt = 8'd0;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // YES is encoded as 0 on car_present.
  assign w_present_nxt = !((w_state_nxt == S_PRESENT) || (w_state_nxt == S_LEAVING));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_car_present <= 1'b1;
      r_car_count   <= 8'd0;
    end else begin
      r_sync1       <= loop_raw;
      r_sync2       <= r_sync1;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_car_present <= w_present_nxt;
      if (w_count_inc) r_car_count <= r_car_count + 8'd1;
    end
  end

`ifdef CAR_SENSOR_STUCK_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stuck_cnt <= 16'd0;
      r_fault     <= 1'b0;
    end else begin
      r_stuck_cnt <= w_stuck_nxt;
      if (w_state_nxt == S_FAULT) r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  logic w_unused_stuck;
  assign w_unused_stuck = (STUCK_CYCLES > 0);
  assign fault          = 1'b0;
`endif

  assign car_present = r_car_present;
  assign car_count   = r_car_count;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Directed bench for car_sensor_conditioner: reset, debounce, hold, glitches, wrap and stuck detection.
module tb_car_sensor_conditioner;

  logic       clk;
  logic       rst_n;
  logic       loop_raw;
  logic       car_present;
  logic [7:0] car_count;
  logic       fault;

  int         n_checks;
  int         n_fail;
  logic [7:0] exp_count;

  car_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .STUCK_CYCLES   (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .loop_raw   (loop_raw),
    .car_present(car_present),
    .car_count  (car_count),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    loop_raw = 1'b0;
    step(3);
    n_checks++;
    if (car_present !== 1'b1) begin n_fail++; $display("FAIL reset_present got %b want 1", car_present); end
    n_checks++;
    if (car_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", car_count); end
    n_checks++;
    if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_checks++;
      if (car_present !== 1'b1 || car_count !== 8'd0 || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold cyc %0d got p=%b c=%0d f=%b want p=1 c=0 f=0", i, car_present, car_count, fault);
      end
    end
    exp_count = 8'd0;
  endtask

  task automatic test_clean_car;
    loop_raw = 1'b1;
    step(5);
    n_checks++;
    if (car_present !== 1'b1) begin n_fail++; $display("FAIL assert_early got %b want 1", car_present); end
    step(1);
    n_checks++;
    if (car_present !== 1'b0) begin n_fail++; $display("FAIL assert_latency got %b want 0", car_present); end
    step(24);
    loop_raw = 1'b0;
    step(9);
    n_checks++;
    if (car_present !== 1'b0 || car_count !== exp_count) begin
      n_fail++;
      $display("FAIL deassert_early got p=%b c=%0d want p=0 c=%0d", car_present, car_count, exp_count);
    end
    step(1);
    exp_count = exp_count + 8'd1;
    n_checks++;
    if (car_present !== 1'b1 || car_count !== exp_count) begin
      n_fail++;
      $display("FAIL deassert_latency got p=%b c=%0d want p=1 c=%0d", car_present, car_count, exp_count);
    end
  endtask

  task automatic test_glitch;
    for (int w = 1; w <= 3; w++) begin
      loop_raw = 1'b1;
      for (int i = 0; i < w; i++) begin
        step(1);
        n_checks++;
        if (car_present !== 1'b1 || car_count !== exp_count) begin
          n_fail++;
          $display("FAIL glitch_hi w=%0d got p=%b c=%0d want p=1 c=%0d", w, car_present, car_count, exp_count);
        end
      end
      loop_raw = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step(1);
        n_checks++;
        if (car_present !== 1'b1 || car_count !== exp_count) begin
          n_fail++;
          $display("FAIL glitch_lo w=%0d got p=%b c=%0d want p=1 c=%0d", w, car_present, car_count, exp_count);
        end
      end
    end
  endtask

  task automatic test_dropout;
    loop_raw = 1'b1;
    step(8);
    n_checks++;
    if (car_present !== 1'b0) begin n_fail++; $display("FAIL dropout_arrive got %b want 0", car_present); end
    loop_raw = 1'b0;
    step(5);
    loop_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      n_checks++;
      if (car_present !== 1'b0 || car_count !== exp_count) begin
        n_fail++;
        $display("FAIL dropout_hold cyc %0d got p=%b c=%0d want p=0 c=%0d", i, car_present, car_count, exp_count);
      end
    end
    loop_raw = 1'b0;
    step(12);
    exp_count = exp_count + 8'd1;
    n_checks++;
    if (car_present !== 1'b1 || car_count !== exp_count) begin
      n_fail++;
      $display("FAIL dropout_depart got p=%b c=%0d want p=1 c=%0d", car_present, car_count, exp_count);
    end
  endtask

  task automatic car_pass;
    loop_raw = 1'b1;
    step(8);
    loop_raw = 1'b0;
    step(12);
    exp_count = exp_count + 8'd1;
  endtask

  task automatic test_wrap;
    rst_n = 1'b0;
    step(1);
    rst_n     = 1'b1;
    exp_count = 8'd0;
    for (int i = 0; i < 255; i++) car_pass();
    n_checks++;
    if (car_count !== 8'd255) begin n_fail++; $display("FAIL count_255 got %0d want 255", car_count); end
    car_pass();
    n_checks++;
    if (car_count !== 8'd0 || exp_count !== 8'd0) begin
      n_fail++;
      $display("FAIL count_wrap got %0d want 0", car_count);
    end
  endtask

  task automatic test_reset_leaving;
    car_pass();
    n_checks++;
    if (car_count !== exp_count) begin n_fail++; $display("FAIL pre_reset_count got %0d want %0d", car_count, exp_count); end
    loop_raw = 1'b1;
    step(8);
    loop_raw = 1'b0;
    step(5);
    n_checks++;
    if (car_present !== 1'b0) begin n_fail++; $display("FAIL leaving_held got %b want 0", car_present); end
    rst_n = 1'b0;
    step(1);
    n_checks++;
    if (car_present !== 1'b1 || car_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_leaving got p=%b c=%0d want p=1 c=0", car_present, car_count);
    end
    rst_n     = 1'b1;
    exp_count = 8'd0;
    step(12);
    n_checks++;
    if (car_present !== 1'b1 || car_count !== 8'd0) begin
      n_fail++;
      $display("FAIL after_reset_leaving got p=%b c=%0d want p=1 c=0", car_present, car_count);
    end
  endtask

  task automatic test_stuck;
    loop_raw = 1'b1;
    step(69);
    n_checks++;
    if (car_present !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_before got p=%b f=%b want p=0 f=0", car_present, fault);
    end
    step(1);
`ifdef CAR_SENSOR_STUCK_DETECT_EN
    n_checks++;
    if (car_present !== 1'b1 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_trip got p=%b f=%b want p=1 f=1", car_present, fault);
    end
    loop_raw = 1'b0;
    step(12);
    n_checks++;
    if (car_present !== 1'b1 || fault !== 1'b1 || car_count !== exp_count) begin
      n_fail++;
      $display("FAIL fault_exit got p=%b f=%b c=%0d want p=1 f=1 c=%0d", car_present, fault, car_count, exp_count);
    end
    car_pass();
    n_checks++;
    if (car_present !== 1'b1 || fault !== 1'b1 || car_count !== exp_count) begin
      n_fail++;
      $display("FAIL fault_count got p=%b f=%b c=%0d want p=1 f=1 c=%0d", car_present, fault, car_count, exp_count);
    end
`else
    n_checks++;
    if (car_present !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL no_stuck got p=%b f=%b want p=0 f=0", car_present, fault);
    end
    loop_raw = 1'b0;
    step(12);
    exp_count = exp_count + 8'd1;
    n_checks++;
    if (car_present !== 1'b1 || fault !== 1'b0 || car_count !== exp_count) begin
      n_fail++;
      $display("FAIL no_stuck_depart got p=%b f=%b c=%0d want p=1 f=0 c=%0d", car_present, fault, car_count, exp_count);
    end
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 8'd0;
    rst_n     = 1'b0;
    loop_raw  = 1'b0;
    test_reset();
    test_clean_car();
    test_glitch();
    test_dropout();
    test_wrap();
    test_reset_leaving();
    test_stuck();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/car_sensor_conditioner.md
Name: car_sensor_conditioner

Overview:
- Drives the `car_present` signal consumed by the farm and highway light controllers. It is the transmitter end of that interface and replaces the nondeterministic sensor for synthesizable builds.
- Synchronizes and debounces a raw farm-road loop-detector input.
- Holds presence across short dropouts.
- Counts departed cars.
- Optionally flags a stuck-high detector.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive high samples required to declare a car present (legal 2..255).
- HOLD_CYCLES, 8, consecutive low samples required to declare the car gone (legal 2..255).
- STUCK_CYCLES, 1024, consecutive PRESENT cycles that trip the stuck fault (legal 4..65535; used only with the macro).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- loop_raw  input  1  asynchronous raw loop-detector level; 1 = metal detected.
- car_present  output  1  boolean encoding: YES = 0, NO = 1; registered.
- car_count  output  8  departed-car count, registered, wraps 255 -> 0.
- fault  output  1  sticky stuck-detector flag, registered.

Behaviour:
- Reset: with rst_n = 0 at a rising edge, the block takes the following values.
  - sync flops = 0, state = IDLE, counters = 0.
  - car_present = NO (1), car_count = 0, fault = 0.
  - Reset mid-operation aborts any debounce or hold in progress; no count increment occurs on that edge.
- Synchronizer:
  - loop_raw passes through 2 flops; s = second flop.
  - The FSM acts only on s.
- FSM states: IDLE, ARRIVING, PRESENT, LEAVING, and FAULT (FAULT only with the macro).
- IDLE (car_present = NO):
  - s = 1 -> ARRIVING, cnt = 1.
  - s = 0 -> stay.
- ARRIVING (car_present = NO):
  - s = 0 -> IDLE, cnt = 0.
  - s = 1 and cnt == DEBOUNCE_CYCLES-1 -> PRESENT.
  - Otherwise cnt++.
- PRESENT (car_present = YES):
  - s = 0 -> LEAVING, cnt = 1.
  - s = 1 -> stay; stuck_cnt++ (macro only).
- LEAVING (car_present = YES, so presence is held through dropouts):
  - s = 1 -> PRESENT, cnt = 0; stuck_cnt is not cleared.
  - s = 0 and cnt == HOLD_CYCLES-1 -> IDLE, car_count++ on the same edge.
  - Otherwise cnt++.
- Latency:
  - Assert: if loop_raw is first sampled high at edge N and held high, car_present = YES after edge N+1+DEBOUNCE_CYCLES (N+5 at default).
  - Deassert: if loop_raw is first sampled low at edge M and held low, car_present = NO and car_count increments after edge M+1+HOLD_CYCLES (M+9 at default).
- Glitch rejection: a high pulse shorter than DEBOUNCE_CYCLES samples returns the FSM to IDLE with no output change and no count change.
- Width rules:
  - cnt is 8 bits; stuck_cnt is 16 bits.
  - Compares use parameter-1, evaluated at elaboration.
- car_present changes only on state transitions. It is never combinationally derived from loop_raw.

Optional Feature:
- Macro: CAR_SENSOR_STUCK_DETECT_EN.
- Defined:
  - stuck_cnt clears on entry to PRESENT from ARRIVING.
  - In PRESENT with s = 1 and stuck_cnt == STUCK_CYCLES-1 -> FAULT.
  - FAULT outputs: car_present = NO (fail-safe; the highway keeps its green) and fault = 1.
  - FAULT exits to IDLE after HOLD_CYCLES consecutive low samples; any high sample resets cnt to 0.
  - FAULT exit does not increment car_count.
  - fault remains 1 until rst_n.
  - While fault = 1, later passes through PRESENT still count normally.
- Undefined:
  - No FAULT state and no stuck_cnt.
  - fault is tied to constant 0.
  - The rest of the behaviour is identical.

Test Plan:
- Reset/idle: rst_n low 3 cycles, loop_raw = 0 -> car_present = 1 (NO), car_count = 0, fault = 0; these values hold for 20 cycles after release.
- Clean car (defaults): loop_raw high from edge 10 for 30 cycles, then low -> car_present = 0 (YES) after edge 15; car_present = 1 after edge 49; car_count = 1 after edge 49.
- Glitches: high pulses of 1, 2 and 3 cycles separated by 5 low cycles -> car_present stays 1 and car_count stays 0 throughout.
- Dropout: car present, then loop_raw low for 5 cycles, then high again -> car_present stays 0 (YES) throughout; no count increment.
- Wrap and reset: 256 clean car passes -> car_count reads 0. Reset asserted during LEAVING -> car_present = 1 and car_count = 0 on the next edge.
- Stuck (macro defined, STUCK_CYCLES = 64):
  - loop_raw held high -> fault = 1 and car_present = 1 at edge 1+1+4+64 after the first high sample.
  - Then loop_raw low 8 cycles -> state IDLE, fault stays 1, car_count unchanged.
  - With the macro undefined, the same stimulus keeps car_present = 0 and fault = 0.
